// File: rtl/key_report.sv
// key_report: turns button presses into short ASCII report messages
// ("B<idx>=<switches>\r\n") written one character at a time to a UART
// transmitter over a Wishbone classic master port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a queued event; pops the FIFO head when non-empty
// LOAD  | popped entry is held; character index cleared
// WRITE | cyc/stb/we high with the current character until ack_i
// GAP   | one idle bus cycle between characters; advance or finish
module key_report #(
  parameter int NUM_BUTTONS = 4,
  parameter int SW_WIDTH    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int APPEND_CRLF = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  input  logic [SW_WIDTH-1:0]    switches_i,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [7:0]             dat_o,
  input  logic                   ack_i,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int HEXD    = (SW_WIDTH + 3) / 4;
  localparam int SW_PAD  = HEXD * 4;
  localparam int ENT_W   = 4 + SW_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = 4;
  // Characters in a message without the optional '!' prefix.
  localparam int MSG_LEN = 3 + HEXD + ((APPEND_CRLF != 0) ? 2 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, GAP} state_t;

  logic [NUM_BUTTONS-1:0] btn_q, btn_d;
  logic [NUM_BUTTONS-1:0] rise;
  logic                   evt_valid;
  logic [3:0]             evt_idx;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] char_idx_q, char_idx_d;
  logic [ENT_W-1:0] cur_q, cur_d;
  logic             bang_q, bang_d;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] char_pos;
  logic [SW_PAD-1:0] sw_pad, sw_shift;
  logic [7:0]       cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Rising-edge detect with lowest-index priority; other simultaneous edges are discarded.
  always_comb begin
    btn_d     = buttons_i;
    rise      = buttons_i & ~btn_q;
    evt_valid = 1'b0;
    evt_idx   = 4'h0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        evt_valid = 1'b1;
        evt_idx   = 4'(i);
      end
    end
  end

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign push       = evt_valid && (!fifo_full || pop);
  assign drop       = evt_valid && fifo_full && !pop;

  // Circular FIFO bookkeeping and sticky overflow flag.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {evt_idx, switches_i};
    end
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (pop) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Character generator: maps the character index of the held entry to ASCII.
  always_comb begin
    char_pos = char_idx_q - IDX_W'(bang_q);
    sw_pad   = SW_PAD'(cur_q[SW_WIDTH-1:0]);
    sw_shift = '0;
    cur_char = 8'h00;
    if (bang_q && (char_idx_q == '0)) begin
      cur_char = 8'h21;
    end else if (char_pos == 4'd0) begin
      cur_char = 8'h42;
    end else if (char_pos == 4'd1) begin
      cur_char = hex_char(cur_q[ENT_W-1 -: 4]);
    end else if (char_pos == 4'd2) begin
      cur_char = 8'h3D;
    end else if (char_pos < IDX_W'(3 + HEXD)) begin
      // Most significant digit first; digit k sits at nibble (HEXD+2-pos).
      sw_shift = sw_pad >> (4 * (IDX_W'(HEXD + 2) - char_pos));
      cur_char = hex_char(sw_shift[3:0]);
    end else if (char_pos == IDX_W'(3 + HEXD)) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
  end

  assign last_idx = IDX_W'(MSG_LEN - 1) + IDX_W'(bang_q);

  // FSM next-state and Wishbone outputs. The FIFO head is captured on the
  // pop edge so LOAD only has to clear the character index.
  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    cur_d      = cur_q;
    bang_d     = bang_q;
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    we_o       = 1'b0;
    dat_o      = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cur_d   = mem_q[rd_ptr_q];
          bang_d  = ovf_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        char_idx_d = '0;
        state_d    = WRITE;
      end
      WRITE: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b1;
        dat_o = cur_char;
        if (ack_i) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (char_idx_q == last_idx) begin
          state_d = IDLE;
        end else begin
          char_idx_d = char_idx_q + IDX_W'(1);
          state_d    = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = !fifo_empty || (state_q != IDLE);
  assign overflow_o = ovf_q;

  // State registers; button history resets to ones so held buttons raise no event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q      <= '1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      char_idx_q <= '0;
      cur_q      <= '0;
      bang_q     <= 1'b0;
    end else begin
      btn_q      <= btn_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      cur_q      <= cur_d;
      bang_q     <= bang_d;
    end
  end

endmodule

// File: tb/tb_key_report.sv
// Bench for key_report: a default instance (4 buttons, 4-bit switches,
// depth 4) and a wide/shallow instance (9-bit switches, depth 2).
module tb_key_report;

  typedef logic [7:0] bq_t [$];

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] btn_a, sw_a;
  logic       cyc_a, stb_a, we_a, busy_a, ovf_a, ack_a;
  logic [7:0] dat_a;
  logic [3:0] btn_b;
  logic [8:0] sw_b;
  logic       cyc_b, stb_b, we_b, busy_b, ovf_b, ack_b;
  logic [7:0] dat_b;

  bq_t cap_a, cap_b;
  int  dly_a = 1, dly_b = 1;
  bit  en_a = 0, en_b = 0, rnd_a = 0;

  key_report dut_a (
    .clk_i(clk), .rst_ni(rst_n), .buttons_i(btn_a), .switches_i(sw_a),
    .cyc_o(cyc_a), .stb_o(stb_a), .we_o(we_a), .dat_o(dat_a), .ack_i(ack_a),
    .busy_o(busy_a), .overflow_o(ovf_a)
  );

  key_report #(.NUM_BUTTONS(4), .SW_WIDTH(9), .FIFO_DEPTH(2), .APPEND_CRLF(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .buttons_i(btn_b), .switches_i(sw_b),
    .cyc_o(cyc_b), .stb_o(stb_b), .we_o(we_b), .dat_o(dat_b), .ack_i(ack_b),
    .busy_o(busy_b), .overflow_o(ovf_b)
  );

  function automatic logic [7:0] hexc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  // Reference message built directly from the message format rules.
  function automatic bq_t model_msg(input bit bang, input int idx, input int sw, input int width);
    bq_t q;
    int  hexd;
    hexd = (width + 3) / 4;
    if (bang) q.push_back(8'h21);
    q.push_back(8'h42);
    q.push_back(hexc(idx));
    q.push_back(8'h3D);
    for (int j = hexd - 1; j >= 0; j--) q.push_back(hexc((sw >> (4 * j)) & 15));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // Slave responders: ack after dly cycles of stb, record the accepted character.
  initial begin
    int w;
    w = 0;
    ack_a = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_a) begin
        ack_a = 1'b0;
        w = 0;
      end else if (en_a && stb_a) begin
        if (w >= dly_a) begin
          ack_a = 1'b1;
          cap_a.push_back(dat_a);
          w = 0;
          if (rnd_a) dly_a = $urandom_range(0, 3);
        end else w++;
      end else w = 0;
    end
  end

  initial begin
    int w;
    w = 0;
    ack_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_b) begin
        ack_b = 1'b0;
        w = 0;
      end else if (en_b && stb_b) begin
        if (w >= dly_b) begin
          ack_b = 1'b1;
          cap_b.push_back(dat_b);
          w = 0;
        end else w++;
      end else w = 0;
    end
  end

  task automatic wait_idle(input bit use_b, input int lim, output bit timed_out);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((use_b ? busy_b : busy_a) && n < lim);
    timed_out = use_b ? busy_b : busy_a;
  endtask

  task automatic test_reset;
    int nb;
    rst_n = 1'b0;
    btn_a = 4'hF; sw_a = 4'h0; btn_b = 4'hF; sw_b = 9'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({cyc_a, stb_a, we_a, busy_a, ovf_a, dat_a} !== 13'h0) begin
      bad++; $display("FAIL reset_a outputs got=%h want=0", {cyc_a, stb_a, we_a, busy_a, ovf_a, dat_a});
    end
    total++;
    if ({cyc_b, stb_b, we_b, busy_b, ovf_b, dat_b} !== 13'h0) begin
      bad++; $display("FAIL reset_b outputs got=%h want=0", {cyc_b, stb_b, we_b, busy_b, ovf_b, dat_b});
    end
    rst_n = 1'b1;
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a || busy_b || stb_a || stb_b) nb++;
    end
    total++;
    if (nb != 0) begin bad++; $display("FAIL reset_held_buttons busy_cycles got=%0d want=0", nb); end
    btn_a = 4'h0; btn_b = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    bq_t exp;
    bit to;
    logic [7:0] got;
    en_a = 1; dly_a = 1; rnd_a = 0;
    cap_a.delete();
    @(negedge clk);
    sw_a = 4'hA; btn_a = 4'b0100;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      total++;
      if (stb_a !== 1'b0) begin bad++; $display("FAIL single_early cycle=N+%0d stb got=%b want=0", i, stb_a); end
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (dat_a !== 8'h42) begin bad++; $display("FAIL single_first_char got=%h want=42", dat_a); end
      end
      total++;
      if (stb_a !== (i % 3 != 2) || cyc_a !== stb_a || we_a !== stb_a || busy_a !== 1'b1) begin
        bad++;
        $display("FAIL single_bus_pattern step=%0d stb/cyc/we/busy got=%b%b%b%b want stb=%0d busy=1",
                 i, stb_a, cyc_a, we_a, busy_a, (i % 3 != 2));
      end
    end
    wait_idle(0, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL single_idle_timeout busy got=1 want=0"); end
    exp = model_msg(0, 2, 4'hA, 4);
    total++;
    if (cap_a.size() != exp.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", cap_a.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < cap_a.size()) ? cap_a[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL single_char%0d got=%h want=%h", i, got, exp[i]); end
    end
    btn_a = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_order;
    bq_t exp, tmp;
    bit to;
    int nb;
    logic [7:0] got;
    en_a = 0; rnd_a = 0; dly_a = 0;
    cap_a.delete();
    @(negedge clk); sw_a = 4'h5; btn_a = 4'b1000;
    @(negedge clk); btn_a = 4'b1001;
    @(negedge clk); btn_a = 4'b1011;
    nb = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy_a !== 1'b1) nb++;
    end
    total++;
    if (nb != 0) begin bad++; $display("FAIL order_busy_stalled low_cycles got=%0d want=0", nb); end
    en_a = 1;
    wait_idle(0, 400, to);
    total++;
    if (to) begin bad++; $display("FAIL order_idle_timeout busy got=1 want=0"); end
    tmp = model_msg(0, 3, 5, 4); foreach (tmp[i]) exp.push_back(tmp[i]);
    tmp = model_msg(0, 0, 5, 4); foreach (tmp[i]) exp.push_back(tmp[i]);
    tmp = model_msg(0, 1, 5, 4); foreach (tmp[i]) exp.push_back(tmp[i]);
    total++;
    if (cap_a.size() != exp.size()) begin bad++; $display("FAIL order_len got=%0d want=%0d", cap_a.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < cap_a.size()) ? cap_a[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL order_char%0d got=%h want=%h", i, got, exp[i]); end
    end
    btn_a = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_priority;
    bq_t exp;
    bit to;
    logic [7:0] got;
    en_a = 1; dly_a = 2; rnd_a = 0;
    cap_a.delete();
    @(negedge clk); sw_a = 4'h3; btn_a = 4'b1011;
    wait_idle(0, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL prio_idle_timeout busy got=1 want=0"); end
    exp = model_msg(0, 0, 3, 4);
    total++;
    if (cap_a.size() != exp.size()) begin bad++; $display("FAIL prio_len got=%0d want=%0d", cap_a.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < cap_a.size()) ? cap_a[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL prio_char%0d got=%h want=%h", i, got, exp[i]); end
    end
    total++;
    if (ovf_a !== 1'b0) begin bad++; $display("FAIL prio_overflow got=%b want=0", ovf_a); end
    btn_a = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow;
    bq_t exp, tmp;
    bit to;
    int n;
    logic [7:0] got;
    en_b = 0; dly_b = 1;
    cap_b.delete();
    @(negedge clk); btn_b = 4'b0001; sw_b = 9'h101;
    @(negedge clk); btn_b = 4'b0011; sw_b = 9'h0A2;
    @(negedge clk); btn_b = 4'b0111; sw_b = 9'h1FF;
    @(negedge clk); btn_b = 4'b1111; sw_b = 9'h033;
    @(negedge clk);
    total++;
    if (ovf_b !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_b); end
    repeat (5) @(negedge clk);
    total++;
    if (ovf_b !== 1'b1 || stb_b !== 1'b1 || busy_b !== 1'b1) begin
      bad++; $display("FAIL ovf_stalled ovf/stb/busy got=%b%b%b want=111", ovf_b, stb_b, busy_b);
    end
    en_b = 1;
    n = 0;
    while (cap_b.size() < 9 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ovf_b !== 1'b0 || cap_b.size() < 9) begin
      bad++; $display("FAIL ovf_clear_on_pop ovf got=%b chars=%0d want ovf=0 chars>=9", ovf_b, cap_b.size());
    end
    wait_idle(1, 400, to);
    total++;
    if (to) begin bad++; $display("FAIL ovf_idle_timeout busy got=1 want=0"); end
    tmp = model_msg(0, 0, 9'h101, 9); foreach (tmp[i]) exp.push_back(tmp[i]);
    tmp = model_msg(1, 1, 9'h0A2, 9); foreach (tmp[i]) exp.push_back(tmp[i]);
    tmp = model_msg(0, 2, 9'h1FF, 9); foreach (tmp[i]) exp.push_back(tmp[i]);
    total++;
    if (cap_b.size() != exp.size()) begin bad++; $display("FAIL ovf_len got=%0d want=%0d", cap_b.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < cap_b.size()) ? cap_b[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL ovf_char%0d got=%h want=%h", i, got, exp[i]); end
    end
    total++;
    if (ovf_b !== 1'b0) begin bad++; $display("FAIL ovf_final got=%b want=0", ovf_b); end
    btn_b = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wide;
    logic [7:0] want [8];
    bit to;
    logic [7:0] got;
    want = '{8'h42, 8'h30, 8'h3D, 8'h31, 8'h46, 8'h33, 8'h0D, 8'h0A};
    en_b = 1; dly_b = 1;
    cap_b.delete();
    @(negedge clk); sw_b = 9'h1F3; btn_b = 4'b0001;
    wait_idle(1, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL wide_idle_timeout busy got=1 want=0"); end
    total++;
    if (cap_b.size() != 8) begin bad++; $display("FAIL wide_len got=%0d want=8", cap_b.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_b.size()) ? cap_b[i] : 8'hxx;
      total++;
      if (got !== want[i]) begin bad++; $display("FAIL wide_char%0d got=%h want=%h", i, got, want[i]); end
    end
    btn_b = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    bq_t exp, tmp;
    bit to;
    int n, idx;
    logic [3:0] v, s;
    logic [7:0] got;
    en_a = 1; rnd_a = 1;
    for (int r = 0; r < 12; r++) begin
      exp.delete();
      cap_a.delete();
      n = $urandom_range(1, 5);
      for (int e = 0; e < n; e++) begin
        v = 4'($urandom_range(1, 15));
        s = 4'($urandom);
        @(negedge clk); btn_a = v; sw_a = s;
        idx = -1;
        for (int b = 0; b < 4; b++) if (v[b] && idx < 0) idx = b;
        tmp = model_msg(0, idx, s, 4);
        foreach (tmp[i]) exp.push_back(tmp[i]);
        @(negedge clk); btn_a = 4'h0; sw_a = 4'($urandom);
      end
      wait_idle(0, 1000, to);
      total++;
      if (to) begin bad++; $display("FAIL rand%0d_idle_timeout busy got=1 want=0", r); end
      total++;
      if (cap_a.size() != exp.size()) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", r, cap_a.size(), exp.size()); end
      foreach (exp[i]) begin
        got = (i < cap_a.size()) ? cap_a[i] : 8'hxx;
        total++;
        if (got !== exp[i]) begin bad++; $display("FAIL rand%0d_char%0d got=%h want=%h", r, i, got, exp[i]); end
      end
      total++;
      if (ovf_a !== 1'b0) begin bad++; $display("FAIL rand%0d_overflow got=%b want=0", r, ovf_a); end
    end
    rnd_a = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bq_t exp;
    bit to;
    int n, nb;
    logic [7:0] got;
    en_a = 0; dly_a = 1; rnd_a = 0;
    cap_a.delete();
    @(negedge clk); sw_a = 4'h9; btn_a = 4'b0100;
    n = 0;
    while (stb_a !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (stb_a !== 1'b1) begin bad++; $display("FAIL rstmid_reach_write stb got=%b want=1", stb_a); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cyc_a, stb_a, we_a, busy_a, ovf_a, dat_a} !== 13'h0) begin
      bad++; $display("FAIL rstmid_immediate outputs got=%h want=0", {cyc_a, stb_a, we_a, busy_a, ovf_a, dat_a});
    end
    @(negedge clk); rst_n = 1'b1;
    nb = 0;
    repeat (15) begin
      @(negedge clk);
      if (stb_a || busy_a) nb++;
    end
    total++;
    if (nb != 0) begin bad++; $display("FAIL rstmid_no_resume active_cycles got=%0d want=0", nb); end
    btn_a = 4'h0;
    en_a = 1;
    @(negedge clk); sw_a = 4'h7; btn_a = 4'b0100;
    wait_idle(0, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL rstmid_idle_timeout busy got=1 want=0"); end
    exp = model_msg(0, 2, 7, 4);
    total++;
    if (cap_a.size() != exp.size()) begin bad++; $display("FAIL rstmid_len got=%0d want=%0d", cap_a.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < cap_a.size()) ? cap_a[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin bad++; $display("FAIL rstmid_char%0d got=%h want=%h", i, got, exp[i]); end
    end
    btn_a = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_order;
    test_priority;
    test_overflow;
    test_wide;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_report.md
KEY_REPORT -- requirements
Module: key_report

Interface
REQ-001 Parameter NUM_BUTTONS, default 4, number of button inputs; legal range 1..16.
REQ-002 Parameter SW_WIDTH, default 4, switch bus width; legal range 1..16.
REQ-003 Parameter FIFO_DEPTH, default 4, pending-event queue depth; power of two, 2..16.
REQ-004 Parameter APPEND_CRLF, default 1, when 1 each message ends with 8'h0D, 8'h0A.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 buttons_i  input  NUM_BUTTONS  debounced button levels, active-high.
REQ-008 switches_i  input  SW_WIDTH  switch levels, sampled at event time.
REQ-009 cyc_o, stb_o, we_o  output  1 each  Wishbone classic master cycle/strobe/write toward uart_tx.
REQ-010 dat_o  output  8  character being written.
REQ-011 ack_i  input  1  Wishbone acknowledge from uart_tx.
REQ-012 busy_o  output  1  high while FIFO non-empty or a message is in progress.
REQ-013 overflow_o  output  1  sticky flag: an event was dropped and not yet reported.

Function
REQ-014 Event detection SHALL register buttons_i each cycle; event = bit high now and low in previous sample.
REQ-015 Simultaneous rising edges SHALL enqueue only the lowest index; others are discarded without setting overflow_o.
REQ-016 An event SHALL push {index, switches_i sampled same cycle} into the FIFO at the end of the detecting cycle.
REQ-017 Push when FIFO full and no pop that cycle SHALL drop the event and set overflow_o; push with simultaneous pop on full SHALL be accepted.
REQ-018 FIFO SHALL be circular; read/write pointers wrap at FIFO_DEPTH; order preserved.
REQ-019 Message format, chars in order: optional '!' (8'h21), 'B' (8'h42), index as one uppercase hex digit, '=' (8'h3D), switch value as ceil(SW_WIDTH/4) uppercase hex digits MSD first, zero-padded, then CR LF if APPEND_CRLF.
REQ-020 '!' SHALL be prefixed iff overflow_o is high when the message is popped; overflow_o SHALL clear in that pop cycle, unless a new drop occurs the same cycle (drop wins, flag stays set).
REQ-021 FSM states: IDLE, LOAD, WRITE, GAP.
REQ-022 IDLE: FIFO non-empty -> pop, go LOAD; else stay.
REQ-023 LOAD: latch entry, character index = 0, go WRITE (one cycle).
REQ-024 WRITE: cyc_o=stb_o=we_o=1, dat_o stable = current char; hold until ack_i sampled high, then go GAP.
REQ-025 GAP: all strobes low one cycle; more chars -> increment index, WRITE; last char -> IDLE.
REQ-026 ack_i outside WRITE SHALL be ignored.
REQ-027 Latency: rising edge in cycle N with empty FIFO and IDLE -> stb_o high in cycle N+3 with first char.
REQ-028 No timeout: WRITE waits indefinitely for ack_i.
REQ-029 busy_o SHALL be combinational from FIFO count and FSM state (not IDLE).

Reset
REQ-030 rst_ni low SHALL immediately force cyc_o, stb_o, we_o, busy_o, overflow_o to 0, dat_o to 8'h00, FSM to IDLE, FIFO empty.
REQ-031 Button history register SHALL reset to all ones so buttons held through reset produce no event.
REQ-032 Reset mid-message SHALL abandon the message; no resume after release.
REQ-033 Reset deassertion is synchronised externally; block SHALL act normally from the first edge after release.

Verification
REQ-034 buttons_i 4'b0000->4'b0100, switches 4'hA, ack_i one cycle after each stb -> dat_o sequence 42,32,3D,41,0D,0A; stb_o first high 3 cycles after edge; GAP cycle between chars.
REQ-035 Edges on buttons 3,0,1 on consecutive cycles, ack_i held low for 50 cycles, then ack_i=1 -> messages "B3=",  "B0=", "B1=" in order; busy_o high throughout, low after final 0A.
REQ-036 FIFO_DEPTH=2, ack_i stalled, 4 distinct events -> 1 in flight, 2 queued, 1 dropped; overflow_o=1; next popped message starts 21,42; overflow_o 0 after that pop.
REQ-037 buttons_i 4'b0000->4'b1011 in one cycle -> single message with index '0'; overflow_o stays 0.
REQ-038 SW_WIDTH=9, switches 9'h1F3, button 0 -> chars 42,30,3D,31,46,33,0D,0A.
REQ-039 rst_ni low mid-WRITE with buttons held -> strobes drop same cycle; after release no event until a button re-presses; FIFO empty.
